// File: rtl/fringe_counter_pkg.sv
// Shared definitions for the fringe counter: quadrature state encodings,
// error counter width and the transition decoder.
package fringe_counter_pkg;

    localparam int ERR_COUNT_WIDTH = 16;

    // Quadrature states as {a, b}; forward order is Q00 -> Q01 -> Q11 -> Q10.
    localparam logic [1:0] Q00 = 2'b00;
    localparam logic [1:0] Q01 = 2'b01;
    localparam logic [1:0] Q11 = 2'b11;
    localparam logic [1:0] Q10 = 2'b10;

    typedef enum logic [1:0] {
        DIR_NONE    = 2'd0,
        DIR_UP      = 2'd1,
        DIR_DOWN    = 2'd2,
        DIR_ILLEGAL = 2'd3
    } quad_dir_e;

    function automatic quad_dir_e quad_decode(input logic [1:0] prev, input logic [1:0] cur);
        quad_dir_e dir;
        dir = DIR_NONE;
        if (prev == cur) begin
            dir = DIR_NONE;
        end else if ((prev ^ cur) == 2'b11) begin
            dir = DIR_ILLEGAL;
        end else begin
            // Only one bit moved: it is either the forward successor or the predecessor.
            case (prev)
                Q00:     dir = (cur == Q01) ? DIR_UP : DIR_DOWN;
                Q01:     dir = (cur == Q11) ? DIR_UP : DIR_DOWN;
                Q11:     dir = (cur == Q10) ? DIR_UP : DIR_DOWN;
                default: dir = (cur == Q00) ? DIR_UP : DIR_DOWN;
            endcase
        end
        return dir;
    endfunction

endpackage

// File: rtl/fringe_counter_schmitt_trigger.sv
// Signed Schmitt trigger with hold band; an inverted threshold pair freezes
// the output and is reported so the beat can be excluded from counting.
module fringe_counter_schmitt_trigger #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         en,
    input  logic [W-1:0] sample,
    input  logic [W-1:0] lower,
    input  logic [W-1:0] upper,
    output logic         state_o,
    output logic         inverted_o
);

    logic state_q;
    logic state_d;

    assign inverted_o = $signed(lower) > $signed(upper);

    always_comb begin
        state_d = state_q;
        if (en && !inverted_o) begin
            if ($signed(sample) > $signed(upper)) begin
                state_d = 1'b1;
            end else if ($signed(sample) < $signed(lower)) begin
                state_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state_q <= 1'b0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/fringe_counter.sv
// Schmitt-triggered quadrature decoder with a signed up/down fringe counter,
// streaming one position word per accepted input beat.
module fringe_counter #(
    parameter int AXIS_TDATA_WIDTH = 32,
    parameter int COUNT_WIDTH      = 32
) (
    input  logic                          SYS_aclk,
    input  logic                          SYS_areset,
    input  logic [AXIS_TDATA_WIDTH/2-1:0] FC_lower_threshold,
    input  logic [AXIS_TDATA_WIDTH/2-1:0] FC_upper_threshold,
    input  logic                          FC_clear,
    output logic [COUNT_WIDTH-1:0]        FC_position,
    output logic [15:0]                   FC_error_count,
    input  logic                          S_AXIS_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0]   S_AXIS_tdata,
    output logic                          S_AXIS_tready,
    output logic                          M_AXIS_tvalid,
    output logic [COUNT_WIDTH-1:0]        M_AXIS_tdata,
    input  logic                          M_AXIS_tready
);

    import fringe_counter_pkg::*;

    localparam int HW = AXIS_TDATA_WIDTH / 2;

    logic advance;
    logic accept;

    // Index 0 is signal_a (low half), index 1 is signal_b (high half).
    logic [1:0] sch_bit;
    logic [1:0] sch_inv;

    logic s1_valid_q, s1_valid_d;
    logic s1_nocount_q, s1_nocount_d;

    logic [COUNT_WIDTH-1:0]     pos_q, pos_d;
    logic [ERR_COUNT_WIDTH-1:0] err_q, err_d;
    logic [1:0]                 prev_q, prev_d;
    logic                       primed_q, primed_d;
    logic                       m_valid_q, m_valid_d;
    logic [COUNT_WIDTH-1:0]     m_data_q, m_data_d;

    logic [1:0] cur_state;
    quad_dir_e  dir;

    // Whole pipeline moves together whenever the output slot can be refilled.
    assign advance       = ~m_valid_q | M_AXIS_tready;
    assign accept        = S_AXIS_tvalid & advance;
    assign S_AXIS_tready = advance;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_schmitt
            fringe_counter_schmitt_trigger #(
                .W (HW)
            ) u_schmitt (
                .clk        (SYS_aclk),
                .srst       (SYS_areset),
                .en         (accept),
                .sample     (S_AXIS_tdata[gi*HW +: HW]),
                .lower      (FC_lower_threshold),
                .upper      (FC_upper_threshold),
                .state_o    (sch_bit[gi]),
                .inverted_o (sch_inv[gi])
            );
        end
    endgenerate

    // The Schmitt flops double as the S1 data register; only valid/no-count live here.
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_nocount_d = s1_nocount_q;
        if (advance) begin
            s1_valid_d = S_AXIS_tvalid;
        end
        if (accept) begin
            s1_nocount_d = |sch_inv;
        end
    end

    assign cur_state = {sch_bit[0], sch_bit[1]};
    assign dir       = quad_decode(prev_q, cur_state);

    always_comb begin
        pos_d     = pos_q;
        err_d     = err_q;
        prev_d    = prev_q;
        primed_d  = primed_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;

        if (advance) begin
            m_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                prev_d   = cur_state;
                primed_d = 1'b1;
                if (primed_q && !s1_nocount_q) begin
                    case (dir)
                        DIR_UP:      pos_d = pos_q + COUNT_WIDTH'(1);
                        DIR_DOWN:    pos_d = pos_q - COUNT_WIDTH'(1);
                        DIR_ILLEGAL: begin
                            if (err_q != {ERR_COUNT_WIDTH{1'b1}}) begin
                                err_d = err_q + ERR_COUNT_WIDTH'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end

        // Clear wins over any step taken in the same cycle.
        if (FC_clear) begin
            pos_d    = '0;
            err_d    = '0;
            primed_d = 1'b0;
        end

        if (advance && s1_valid_q) begin
            m_data_d = pos_d;
        end
    end

    always_ff @(posedge SYS_aclk) begin
        if (SYS_areset) begin
            s1_valid_q   <= 1'b0;
            s1_nocount_q <= 1'b0;
            pos_q        <= '0;
            err_q        <= '0;
            prev_q       <= Q00;
            primed_q     <= 1'b0;
            m_valid_q    <= 1'b0;
            m_data_q     <= '0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_nocount_q <= s1_nocount_d;
            pos_q        <= pos_d;
            err_q        <= err_d;
            prev_q       <= prev_d;
            primed_q     <= primed_d;
            m_valid_q    <= m_valid_d;
            m_data_q     <= m_data_d;
        end
    end

    assign FC_position    = pos_q;
    assign FC_error_count = err_q;
    assign M_AXIS_tvalid  = m_valid_q;
    assign M_AXIS_tdata   = m_data_q;

endmodule
